// File: rtl/xor_unit_arbiter.sv
// xor_unit_arbiter: two requesters share one registered XOR unit.
// A round-robin pointer settles simultaneous requests. The result is held
// in a single output register until the consumer acknowledges it. op_count
// counts acknowledged operations modulo 256.
module xor_unit_arbiter #(
  parameter int SIZE = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req0,
  input  logic            req1,
  input  logic [SIZE-1:0] a0,
  input  logic [SIZE-1:0] b0,
  input  logic [SIZE-1:0] a1,
  input  logic [SIZE-1:0] b1,
  output logic            gnt0,
  output logic            gnt1,
  output logic [SIZE-1:0] out,
  output logic            out_valid,
  output logic            out_id,
  input  logic            out_ack,
  output logic [7:0]      op_count
);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_VALID = 1'b1
  } state_e;

  state_e          state_q, state_d;
  logic            prio_q, prio_d;
  logic [SIZE-1:0] out_q, out_d;
  logic            out_id_q, out_id_d;
  logic            gnt0_q, gnt0_d;
  logic            gnt1_q, gnt1_d;
  logic [7:0]      cnt_q, cnt_d;
  logic            winner_s;

  // Pick the winner: a lone requester always wins, a tie goes to prio.
  always_comb begin
    winner_s = 1'b0;
    if (req0 && req1) begin
      winner_s = prio_q;
    end else if (req1) begin
      winner_s = 1'b1;
    end else begin
      winner_s = 1'b0;
    end
  end

  // Next-state logic: grant from IDLE, retire the result on ack in VALID.
  always_comb begin
    state_d  = state_q;
    prio_d   = prio_q;
    out_d    = out_q;
    out_id_d = out_id_q;
    gnt0_d   = 1'b0;
    gnt1_d   = 1'b0;
    cnt_d    = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (req0 || req1) begin
          state_d  = ST_VALID;
          out_d    = winner_s ? (a1 ^ b1) : (a0 ^ b0);
          out_id_d = winner_s;
          gnt0_d   = ~winner_s;
          gnt1_d   = winner_s;
          prio_d   = ~winner_s;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_VALID: begin
        // Requests are ignored here; only the consumer ack moves us on.
        if (out_ack) begin
          state_d = ST_IDLE;
          cnt_d   = cnt_q + 8'd1;
        end else begin
          state_d = ST_VALID;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State register with asynchronous active-low clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      prio_q   <= 1'b0;
      out_q    <= {SIZE{1'b0}};
      out_id_q <= 1'b0;
      gnt0_q   <= 1'b0;
      gnt1_q   <= 1'b0;
      cnt_q    <= 8'd0;
    end else begin
      state_q  <= state_d;
      prio_q   <= prio_d;
      out_q    <= out_d;
      out_id_q <= out_id_d;
      gnt0_q   <= gnt0_d;
      gnt1_q   <= gnt1_d;
      cnt_q    <= cnt_d;
    end
  end

  assign gnt0      = gnt0_q;
  assign gnt1      = gnt1_q;
  assign out       = out_q;
  assign out_id    = out_id_q;
  assign out_valid = (state_q == ST_VALID);
  assign op_count  = cnt_q;

endmodule

// File: tb/tb_xor_unit_arbiter.sv
// Self-checking bench for xor_unit_arbiter: directed vector table, corner
// sequences, and random traffic compared against a transaction-level model.
module tb_xor_unit_arbiter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req0 = 1'b0, req1 = 1'b0;
  logic [7:0] a0 = 8'h00, b0 = 8'h00, a1 = 8'h00, b1 = 8'h00;
  logic       gnt0, gnt1, out_valid, out_id;
  logic [7:0] out;
  logic       out_ack = 1'b0;
  logic [7:0] op_count;

  int checks = 0;
  int errors = 0;

  // Model: a pending result, its owner and value, the tie-break pointer,
  // and a plain integer count of completed operations.
  bit       m_busy;
  bit       m_prio;
  bit [7:0] m_out;
  bit       m_id;
  bit       m_g0, m_g1;
  int       m_done;

  typedef struct {
    bit       rst;
    bit       r0, r1;
    bit [7:0] a0, b0, a1, b1;
    bit       ack;
    bit       e_g0, e_g1;
    bit [7:0] e_out;
    bit       e_v, e_id;
    bit [7:0] e_cnt;
  } vec_t;

  vec_t tbl[10];

  xor_unit_arbiter #(.SIZE(8)) dut (
    .clk(clk), .rst_n(rst_n), .req0(req0), .req1(req1),
    .a0(a0), .b0(b0), .a1(a1), .b1(b1),
    .gnt0(gnt0), .gnt1(gnt1), .out(out), .out_valid(out_valid),
    .out_id(out_id), .out_ack(out_ack), .op_count(op_count)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(bit rst, bit r0, bit r1, bit [7:0] va0, bit [7:0] vb0,
                              bit [7:0] va1, bit [7:0] vb1, bit ack, bit g0, bit g1,
                              bit [7:0] eo, bit v, bit id, bit [7:0] ec);
    vec_t t;
    t.rst = rst; t.r0 = r0; t.r1 = r1;
    t.a0 = va0; t.b0 = vb0; t.a1 = va1; t.b1 = vb1; t.ack = ack;
    t.e_g0 = g0; t.e_g1 = g1; t.e_out = eo; t.e_v = v; t.e_id = id; t.e_cnt = ec;
    return t;
  endfunction

  task automatic model_reset();
    m_busy = 1'b0; m_prio = 1'b0; m_out = 8'h00; m_id = 1'b0;
    m_g0 = 1'b0; m_g1 = 1'b0; m_done = 0;
  endtask

  // Apply one clock worth of the rules to the model, using the inputs as
  // they stand at the edge.
  task automatic model_edge();
    bit w;
    m_g0 = 1'b0;
    m_g1 = 1'b0;
    if (!m_busy) begin
      if (req0 || req1) begin
        if (req0 && req1) w = m_prio;
        else              w = req1;
        m_out  = w ? (a1 ^ b1) : (a0 ^ b0);
        m_id   = w;
        m_g0   = !w;
        m_g1   = w;
        m_prio = !w;
        m_busy = 1'b1;
      end
    end else if (out_ack) begin
      m_busy = 1'b0;
      m_done = m_done + 1;
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".gnt0"},      gnt0,      m_g0);
    chk({tag, ".gnt1"},      gnt1,      m_g1);
    chk({tag, ".out"},       out,       m_out);
    chk({tag, ".out_valid"}, out_valid, m_busy);
    chk({tag, ".out_id"},    out_id,    m_id);
    chk({tag, ".op_count"},  op_count,  m_done % 256);
    chk({tag, ".gnt_excl"},  gnt0 & gnt1, 1'b0);
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_model(tag);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    #1;
    check_model("reset");
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    // Directed table: single request, then contention from a fresh reset.
    tbl[0] = mk(1, 1, 0, 8'hF0, 8'h3C, 8'h00, 8'h00, 1, 1, 0, 8'hCC, 1, 0, 8'd0);
    tbl[1] = mk(0, 0, 0, 8'hF0, 8'h3C, 8'h00, 8'h00, 1, 0, 0, 8'hCC, 0, 0, 8'd1);
    tbl[2] = mk(1, 1, 1, 8'hF0, 8'h3C, 8'hFF, 8'h0F, 1, 1, 0, 8'hCC, 1, 0, 8'd0);
    tbl[3] = mk(0, 1, 1, 8'hF0, 8'h3C, 8'hFF, 8'h0F, 1, 0, 0, 8'hCC, 0, 0, 8'd1);
    tbl[4] = mk(0, 1, 1, 8'hF0, 8'h3C, 8'hFF, 8'h0F, 1, 0, 1, 8'hF0, 1, 1, 8'd1);
    tbl[5] = mk(0, 1, 1, 8'hF0, 8'h3C, 8'hFF, 8'h0F, 1, 0, 0, 8'hF0, 0, 1, 8'd2);
    tbl[6] = mk(0, 1, 1, 8'hF0, 8'h3C, 8'hFF, 8'h0F, 1, 1, 0, 8'hCC, 1, 0, 8'd2);
    tbl[7] = mk(0, 1, 1, 8'hF0, 8'h3C, 8'hFF, 8'h0F, 1, 0, 0, 8'hCC, 0, 0, 8'd3);
    tbl[8] = mk(0, 1, 1, 8'hF0, 8'h3C, 8'hFF, 8'h0F, 1, 0, 1, 8'hF0, 1, 1, 8'd3);
    tbl[9] = mk(0, 1, 1, 8'hF0, 8'h3C, 8'hFF, 8'h0F, 1, 0, 0, 8'hF0, 0, 1, 8'd4);

    model_reset();
    for (int i = 0; i < 10; i++) begin
      if (tbl[i].rst) begin
        req0 = 1'b0; req1 = 1'b0; out_ack = 1'b0;
        do_reset();
      end
      req0 = tbl[i].r0; req1 = tbl[i].r1;
      a0 = tbl[i].a0; b0 = tbl[i].b0; a1 = tbl[i].a1; b1 = tbl[i].b1;
      out_ack = tbl[i].ack;
      step("tbl");
      chk($sformatf("tbl%0d.gnt0", i),      gnt0,      tbl[i].e_g0);
      chk($sformatf("tbl%0d.gnt1", i),      gnt1,      tbl[i].e_g1);
      chk($sformatf("tbl%0d.out", i),       out,       tbl[i].e_out);
      chk($sformatf("tbl%0d.out_valid", i), out_valid, tbl[i].e_v);
      chk($sformatf("tbl%0d.out_id", i),    out_id,    tbl[i].e_id);
      chk($sformatf("tbl%0d.op_count", i),  op_count,  tbl[i].e_cnt);
    end

    // Back-pressure: result pending, ack low for 5 cycles, req1 toggling.
    req0 = 1'b0; req1 = 1'b0; out_ack = 1'b0;
    do_reset();
    req0 = 1'b1; a0 = 8'h12; b0 = 8'h34;
    step("bp_grant");
    chk("bp_grant.gnt0", gnt0, 1'b1);
    req0 = 1'b0;
    for (int i = 0; i < 5; i++) begin
      req1 = ~req1;
      a1 = 8'(i * 37);
      b1 = 8'h5A;
      step("bp_hold");
      chk("bp_hold.out", out, 8'h26);
      chk("bp_hold.out_id", out_id, 1'b0);
      chk("bp_hold.out_valid", out_valid, 1'b1);
      chk("bp_hold.gnt", {gnt0, gnt1}, 2'b00);
      chk("bp_hold.op_count", op_count, 8'd0);
    end
    req1 = 1'b0; out_ack = 1'b1;
    step("bp_ack");
    chk("bp_ack.op_count", op_count, 8'd1);
    chk("bp_ack.out_valid", out_valid, 1'b0);

    // Reset mid-operation, then a request on the very first edge after release.
    req0 = 1'b1; a0 = 8'h55; b0 = 8'h0F; out_ack = 1'b0;
    step("mid_grant");
    chk("mid_grant.out", out, 8'h5A);
    req0 = 1'b0;
    #3;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("mid_rst.gnt", {gnt0, gnt1}, 2'b00);
    chk("mid_rst.out", out, 8'h00);
    chk("mid_rst.out_valid", out_valid, 1'b0);
    chk("mid_rst.out_id", out_id, 1'b0);
    chk("mid_rst.op_count", op_count, 8'd0);
    out_ack = 1'b1;
    @(posedge clk);
    #1;
    chk("mid_rst_hold.op_count", op_count, 8'd0);
    chk("mid_rst_hold.out_valid", out_valid, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    req1 = 1'b1; a1 = 8'hA5; b1 = 8'hFF;
    step("post_rst");
    chk("post_rst.gnt1", gnt1, 1'b1);
    chk("post_rst.out", out, 8'h5A);

    // Single requester 1 held: wins every operation regardless of prio.
    req0 = 1'b0; req1 = 1'b0; out_ack = 1'b0;
    do_reset();
    req1 = 1'b1; a1 = 8'h3C; b1 = 8'hC3; out_ack = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step("rep_grant");
      chk("rep_grant.gnt1", gnt1, 1'b1);
      chk("rep_grant.out_id", out_id, 1'b1);
      chk("rep_grant.out", out, 8'hFF);
      step("rep_ack");
    end
    chk("rep.op_count", op_count, 8'd4);

    // Counter wrap: 256 acknowledged operations from reset.
    req0 = 1'b0; req1 = 1'b0; out_ack = 1'b1;
    do_reset();
    for (int i = 0; i < 256; i++) begin
      req0 = 1'b1; a0 = 8'(i); b0 = 8'hFF;
      step("wrap_grant");
      req0 = 1'b0;
      step("wrap_ack");
      if (i == 254) chk("wrap.op_count_255", op_count, 8'd255);
    end
    chk("wrap.op_count_0", op_count, 8'd0);

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      req0 = 1'($urandom_range(0, 1));
      req1 = 1'($urandom_range(0, 1));
      a0 = 8'($urandom); b0 = 8'($urandom);
      a1 = 8'($urandom); b1 = 8'($urandom);
      out_ack = ($urandom_range(0, 3) != 0);
      step("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
